// File: rtl/ah_func_arbiter.sv
// rtl/ah_func_arbiter.sv - round-robin, credit-guarded sharing of the ah_func pipe between two requesters
// Optional statistics counters are compiled in with AH_FUNC_ARBITER_STATS_EN.
module ah_func_arbiter #(
    parameter int LATENCY    = 57,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_dataa,
    input  logic [31:0] req0_datab,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_dataa,
    input  logic [31:0] req1_datab,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_data,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_data,
    output logic [31:0] pipe_dataa,
    output logic [31:0] pipe_datab,
    input  logic [31:0] pipe_result,
`ifdef AH_FUNC_ARBITER_STATS_EN
    output logic [31:0] stat_issued0,
    output logic [31:0] stat_issued1,
    output logic [31:0] stat_stall,
`endif
    output logic        busy
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [CW-1:0]    credit    [2];
    logic [CW-1:0]    count     [2];
    logic [CW-1:0]    count_nxt [2];
    logic [AW-1:0]    wptr      [2];
    logic [AW-1:0]    rptr      [2];
    logic [31:0]      mem       [2][FIFO_DEPTH];
    logic [LATENCY:0] tag_valid;
    logic [LATENCY:0] tag_id;
    logic [1:0]       valid;
    logic [1:0]       rsp_ready;
    logic [1:0]       elig;
    logic [1:0]       grant;
    logic [1:0]       wr;
    logic [1:0]       pop;
    logic             prio;
    logic             issue;

    assign valid     = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};

    // prio=0 favours requester 0 when both are eligible
    always_comb begin
        elig  = '0;
        grant = '0;
        for (int n = 0; n < 2; n++) begin
            elig[n] = reset_n && valid[n] && (credit[n] != '0);
        end
        grant[0] = elig[0] && (!elig[1] || !prio);
        grant[1] = elig[1] && (!elig[0] || prio);
    end

    assign issue      = |grant;
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    assign wr[0] = tag_valid[LATENCY] && !tag_id[LATENCY];
    assign wr[1] = tag_valid[LATENCY] && tag_id[LATENCY];

    assign rsp0_valid = (count[0] != '0);
    assign rsp1_valid = (count[1] != '0);
    assign rsp0_data  = mem[0][rptr[0]];
    assign rsp1_data  = mem[1][rptr[1]];
    assign pop        = {rsp1_valid && rsp_ready[1], rsp0_valid && rsp_ready[0]};

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            count_nxt[n] = count[n];
            if (wr[n] && !pop[n]) begin
                count_nxt[n] = count[n] + CW'(1);
            end else if (!wr[n] && pop[n]) begin
                count_nxt[n] = count[n] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_valid  <= '0;
            tag_id     <= '0;
            pipe_dataa <= '0;
            pipe_datab <= '0;
            prio       <= 1'b0;
            busy       <= 1'b0;
            for (int n = 0; n < 2; n++) begin
                credit[n] <= CW'(FIFO_DEPTH);
                count[n]  <= '0;
                wptr[n]   <= '0;
                rptr[n]   <= '0;
            end
        end else begin
            tag_valid  <= {tag_valid[LATENCY-1:0], issue};
            tag_id     <= {tag_id[LATENCY-1:0], grant[1]};
            pipe_dataa <= grant[0] ? req0_dataa : (grant[1] ? req1_dataa : 32'h0);
            pipe_datab <= grant[0] ? req0_datab : (grant[1] ? req1_datab : 32'h0);
            if (issue) begin
                prio <= grant[0];
            end
            // busy tracks next-state occupancy so it is exact rather than a cycle late
            busy <= (|tag_valid[LATENCY-1:0]) | issue |
                    (count_nxt[0] != '0) | (count_nxt[1] != '0);
            for (int n = 0; n < 2; n++) begin
                count[n] <= count_nxt[n];
                if (wr[n]) begin
                    wptr[n] <= wptr[n] + AW'(1);
                end
                if (pop[n]) begin
                    rptr[n] <= rptr[n] + AW'(1);
                end
                if (grant[n] && !pop[n]) begin
                    credit[n] <= credit[n] - CW'(1);
                end else if (!grant[n] && pop[n]) begin
                    credit[n] <= credit[n] + CW'(1);
                end
            end
        end
    end

    // storage needs no reset: occupancy counters gate visibility
    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (wr[n]) begin
                mem[n][wptr[n]] <= pipe_result;
            end
        end
    end

`ifdef AH_FUNC_ARBITER_STATS_EN
    logic stall;
    assign stall = (req0_valid && credit[0] == '0) || (req1_valid && credit[1] == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_issued0 <= '0;
            stat_issued1 <= '0;
            stat_stall   <= '0;
        end else begin
            if (grant[0] && stat_issued0 != 32'hFFFF_FFFF) begin
                stat_issued0 <= stat_issued0 + 32'd1;
            end
            if (grant[1] && stat_issued1 != 32'hFFFF_FFFF) begin
                stat_issued1 <= stat_issued1 + 32'd1;
            end
            if (stall && stat_stall != 32'hFFFF_FFFF) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_ah_func_arbiter.sv
// tb/tb_ah_func_arbiter.sv - scoreboard bench for ah_func_arbiter with a delay-line add pipe model
module tb_ah_func_arbiter;
    localparam int LATENCY    = 57;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_dataa, req0_datab, req1_dataa, req1_datab;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp0_data, rsp1_data;
    logic [31:0] pipe_dataa, pipe_datab, pipe_result;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int out0        = 0;
    int out1        = 0;
    logic [31:0] exp0 [$];
    logic [31:0] exp1 [$];
    logic [31:0] dly [LATENCY];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ah_func_arbiter #(.LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_dataa(req0_dataa), .req0_datab(req0_datab),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_dataa(req1_dataa), .req1_datab(req1_datab),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .pipe_dataa(pipe_dataa), .pipe_datab(pipe_datab), .pipe_result(pipe_result),
        .busy(busy)
    );

    // datapath model: add of the registered operands, LATENCY cycles later
    always @(posedge clk) begin
        dly[0] <= pipe_dataa + pipe_datab;
        for (int i = 1; i < LATENCY; i++) dly[i] <= dly[i-1];
    end
    assign pipe_result = dly[LATENCY-1];

    // scoreboard: push on grant, compare on pop
    always @(negedge clk) begin
        if (reset_n) begin
            if (req0_ready && req1_ready) begin
                vectors++; miscompares++;
                $display("FAIL dual_grant: both readies high at cycle %0d, required at most one", cyc);
            end
            if (req0_ready) begin
                vectors++;
                if (req0_valid !== 1'b1) begin
                    miscompares++; $display("FAIL ready0_no_valid: valid=%b required 1", req0_valid);
                end
                exp0.push_back(req0_dataa + req0_datab);
                out0++;
                if (out0 > FIFO_DEPTH) begin
                    miscompares++; $display("FAIL overflow0: outstanding=%0d required <=%0d", out0, FIFO_DEPTH);
                end
            end
            if (req1_ready) begin
                vectors++;
                if (req1_valid !== 1'b1) begin
                    miscompares++; $display("FAIL ready1_no_valid: valid=%b required 1", req1_valid);
                end
                exp1.push_back(req1_dataa + req1_datab);
                out1++;
                if (out1 > FIFO_DEPTH) begin
                    miscompares++; $display("FAIL overflow1: outstanding=%0d required <=%0d", out1, FIFO_DEPTH);
                end
            end
            if (rsp0_valid && rsp0_ready) begin
                vectors++;
                out0--;
                if (exp0.size() == 0) begin
                    miscompares++; $display("FAIL rsp0_unexpected: data=%h with empty scoreboard", rsp0_data);
                end else begin
                    logic [31:0] e;
                    e = exp0.pop_front();
                    if (rsp0_data !== e) begin
                        miscompares++; $display("FAIL rsp0_data: got %h required %h", rsp0_data, e);
                    end
                end
            end
            if (rsp1_valid && rsp1_ready) begin
                vectors++;
                out1--;
                if (exp1.size() == 0) begin
                    miscompares++; $display("FAIL rsp1_unexpected: data=%h with empty scoreboard", rsp1_data);
                end else begin
                    logic [31:0] e;
                    e = exp1.pop_front();
                    if (rsp1_data !== e) begin
                        miscompares++; $display("FAIL rsp1_data: got %h required %h", rsp1_data, e);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drain();
        bit done = 0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (busy === 1'b0) done = 1;
        end
        vectors++;
        if (!done) begin
            miscompares++; $display("FAIL drain_timeout: busy=%b required 0 within 300 cycles", busy);
        end
        vectors++;
        if (exp0.size() != 0 || exp1.size() != 0) begin
            miscompares++; $display("FAIL drain_left: pending %0d/%0d required 0/0", exp0.size(), exp1.size());
        end
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
        req0_dataa = 32'h1; req0_datab = 32'h2; req1_dataa = 32'h3; req1_datab = 32'h4;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags: rdy=%b%b rsp=%b%b busy=%b required all 0",
                     req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy);
        end
        vectors++;
        if (pipe_dataa !== 32'h0 || pipe_datab !== 32'h0) begin
            miscompares++; $display("FAIL reset_pipe: %h/%h required 0/0", pipe_dataa, pipe_datab);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        reset_n = 1'b1;
        repeat (4) step();
    endtask

    task automatic test_single();
        int c = 0;
        int first = -1;
        int seen1 = 0;
        req0_dataa = 32'h4000_0000; req0_datab = 32'h3f80_0000; req0_valid = 1'b1;
        @(negedge clk);
        vectors++;
        if (req0_ready !== 1'b1) begin
            miscompares++; $display("FAIL single_grant: ready0=%b required 1", req0_ready);
        end
        c = cyc;
        step();
        req0_valid = 1'b0;
        vectors++;
        if (pipe_dataa !== 32'h4000_0000 || pipe_datab !== 32'h3f80_0000) begin
            miscompares++; $display("FAIL single_pipe_in: %h/%h required 40000000/3f800000", pipe_dataa, pipe_datab);
        end
        for (int i = 0; i < 100 && first < 0; i++) begin
            @(negedge clk);
            if (rsp1_valid) seen1++;
            if (rsp0_valid) begin
                first = cyc;
                vectors++;
                if (rsp0_data !== 32'h7f80_0000) begin
                    miscompares++; $display("FAIL single_data: got %h required 7f800000", rsp0_data);
                end
            end
        end
        vectors++;
        if (first - c != LATENCY + 2) begin
            miscompares++; $display("FAIL single_latency: got %0d cycles required %0d", first - c, LATENCY + 2);
        end
        vectors++;
        if (seen1 != 0) begin
            miscompares++; $display("FAIL single_rsp1: rsp1_valid seen %0d cycles required 0", seen1);
        end
        step();
        drain();
    endtask

    task automatic test_alternate();
        logic pg = 1'b0;
        logic g0, g1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_dataa = $urandom; req0_datab = $urandom; req1_dataa = $urandom; req1_datab = $urandom;
        for (int i = 0; i < 2 * FIFO_DEPTH; i++) begin
            @(negedge clk);
            g0 = req0_ready; g1 = req1_ready;
            vectors++;
            if ((g0 ^ g1) !== 1'b1) begin
                miscompares++; $display("FAIL alt_one_grant: grants=%b%b at step %0d required exactly one", g0, g1, i);
            end
            if (i > 0) begin
                vectors++;
                if (g0 === pg) begin
                    miscompares++; $display("FAIL alt_order: grant0=%b repeated at step %0d required alternation", g0, i);
                end
            end
            pg = g0;
            step();
            if (g0) begin req0_dataa = $urandom; req0_datab = $urandom; end
            if (g1) begin req1_dataa = $urandom; req1_datab = $urandom; end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();
    endtask

    task automatic test_credit();
        int n = 0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_dataa = 32'h100; req0_datab = 32'h1;
        for (int i = 0; i < 75; i++) begin
            @(negedge clk);
            if (req0_ready) n++;
            step();
            if (req0_ready === 1'b0) req0_dataa = req0_dataa + 32'h10;
        end
        @(negedge clk);
        vectors++;
        if (n != FIFO_DEPTH || req0_ready !== 1'b0 || rsp0_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL credit_limit: grants=%0d ready0=%b rsp0_valid=%b required %0d/0/1",
                     n, req0_ready, rsp0_valid, FIFO_DEPTH);
        end
        step();
        req1_valid = 1'b1;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            req1_dataa = $urandom; req1_datab = $urandom;
            @(negedge clk);
            vectors++;
            if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
                miscompares++; $display("FAIL credit_req1_flow: rdy0=%b rdy1=%b step %0d required 0/1", req0_ready, req1_ready, i);
            end
            step();
        end
        req1_valid = 1'b0;
        req0_dataa = 32'h5000;
        rsp0_ready = 1'b1;
        @(negedge clk);
        step();
        rsp0_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (req0_ready !== (i == 0)) begin
                miscompares++; $display("FAIL credit_one_more: ready0=%b at %0d after pop required %b", req0_ready, i + 1, i == 0);
            end
            step();
            req0_dataa = req0_dataa + 32'h1;
        end
        rsp0_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++;
            if (req0_ready !== (k >= 1 && k <= 3)) begin
                miscompares++; $display("FAIL pop_issue_same: ready0=%b at k=%0d required %b", req0_ready, k, k >= 1 && k <= 3);
            end
            step();
            req0_dataa = req0_dataa + 32'h3;
        end
        req0_valid = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int stray = 0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_dataa = 32'hA; req0_datab = 32'hB;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            step();
        end
        req0_valid = 1'b0;
        repeat (20) step();
        reset_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || rsp0_valid !== 1'b0 || req0_ready !== 1'b0) begin
            miscompares++; $display("FAIL midreset_now: busy=%b rsp0_valid=%b ready0=%b required 0/0/0", busy, rsp0_valid, req0_ready);
        end
        exp0.delete(); exp1.delete(); out0 = 0; out1 = 0;
        repeat (2) step();
        reset_n = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid || busy) stray++;
        end
        vectors++;
        if (stray != 0) begin
            miscompares++; $display("FAIL midreset_stray: %0d cycles with rsp_valid/busy required 0", stray);
        end
        step();
        rsp0_ready = 1'b0; req0_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (req0_ready) n++;
            step();
        end
        vectors++;
        if (n != FIFO_DEPTH) begin
            miscompares++; $display("FAIL midreset_credit: grants=%0d required %0d", n, FIFO_DEPTH);
        end
        req0_valid = 1'b0;
        drain();
    endtask

    initial begin
        #200000;
        miscompares++;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_credit();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
